// File: rtl/key_dispatch_pkg.sv
// Shared definitions for the key dispatcher: FSM states, client map, key width.
package key_dispatch_pkg;

  localparam int KEY_WIDTH   = 192;
  localparam int NUM_CLIENTS = 5;

  // Client index doubles as the ROM address holding that client's key.
  localparam int CLIENT_AES  = 0;
  localparam int CLIENT_JTAG = 1;
  localparam int CLIENT_ACM0 = 2;
  localparam int CLIENT_ACM1 = 3;
  localparam int CLIENT_ACM2 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    RESP  = 2'd2,
    SCRUB = 2'd3
  } state_e;

endpackage

// File: rtl/key_dispatch_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer (wrapping) wins.
module key_dispatch_rr_arbiter #(
  parameter int NumClients = 5,
  localparam int IdxW = (NumClients > 1) ? $clog2(NumClients) : 1
) (
  input  logic [NumClients-1:0] req_i,
  input  logic [IdxW-1:0]       ptr_i,
  output logic [NumClients-1:0] gnt_o,
  output logic [IdxW-1:0]       idx_o,
  output logic                  any_o
);

  logic [2*NumClients-1:0] w_req_dbl;
  logic [NumClients-1:0]   w_rot;
  logic [IdxW-1:0]         w_off;
  logic [IdxW:0]           w_sum;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign w_req_dbl = {req_i, req_i};
  assign w_rot     = NumClients'(w_req_dbl >> ptr_i);
  assign any_o     = |w_rot;

  // Lowest set bit of the rotated vector is the winner's offset from the pointer.
  always_comb begin
    w_off = '0;
    for (int k = NumClients - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IdxW'(k);
      end
    end
  end

  assign w_sum = {1'b0, w_off} + {1'b0, ptr_i};
  assign idx_o = (w_sum >= (IdxW+1)'(NumClients)) ? IdxW'(w_sum - (IdxW+1)'(NumClients))
                                                 : IdxW'(w_sum);
  assign gnt_o = any_o ? (NumClients'(1) << idx_o) : '0;

endmodule

// File: rtl/key_dispatch.sv
// Key dispatcher: arbitrates client key requests, reads the granted client's
// ROM slot, returns the key over valid/ready and scrubs the internal copy.
module key_dispatch
  import key_dispatch_pkg::*;
#(
  parameter int NumClients = NUM_CLIENTS,
  parameter int KeyWidth   = KEY_WIDTH,
  parameter logic [NumClients-1:0] ReadOnceMask = NumClients'(5'b00010),
  localparam int IdxW = (NumClients > 1) ? $clog2(NumClients) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumClients-1:0] req_valid_i,
  output logic [NumClients-1:0] req_ready_o,
  output logic [31:0]           rom_addr_o,
  input  logic [KeyWidth-1:0]   rom_rdata_i,
  output logic [KeyWidth-1:0]   key_o,
  output logic [NumClients-1:0] key_valid_o,
  output logic                  key_err_o,
  input  logic [NumClients-1:0] key_ready_i,
  output logic                  busy_o
);

  state_e                r_state;
  logic [IdxW-1:0]       r_rr_ptr;
  logic [IdxW-1:0]       r_grant;
  logic [KeyWidth-1:0]   r_key;
  logic                  r_err;
  logic [NumClients-1:0] r_used;

  logic [NumClients-1:0] w_arb_req;
  logic [NumClients-1:0] w_gnt;
  logic [IdxW-1:0]       w_idx;
  logic                  w_any;
  logic [NumClients-1:0] w_grant_onehot;
  logic                  w_in_idle;
  logic                  w_in_read;
  logic                  w_in_resp;
  logic                  w_resp_hs;
  logic                  w_ro_violation;
  logic [IdxW-1:0]       w_ptr_next;

  assign w_in_idle = (r_state == IDLE);
  assign w_in_read = (r_state == READ);
  assign w_in_resp = (r_state == RESP);

  // Requests are only looked at while idle; nothing is latched otherwise.
  assign w_arb_req = w_in_idle ? req_valid_i : '0;

  key_dispatch_rr_arbiter #(
    .NumClients(NumClients)
  ) u_arb (
    .req_i (w_arb_req),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_idx),
    .any_o (w_any)
  );

  assign w_grant_onehot = NumClients'(1) << r_grant;
  assign w_resp_hs      = w_in_resp && |(key_ready_i & w_grant_onehot);
  assign w_ro_violation = |(ReadOnceMask & r_used & w_gnt);
  assign w_ptr_next     = (w_idx == IdxW'(NumClients - 1)) ? '0 : w_idx + 1'b1;

  assign req_ready_o = w_gnt;
  assign rom_addr_o  = w_in_read ? 32'(r_grant) : 32'd0;
  assign key_valid_o = w_in_resp ? w_grant_onehot : '0;
  assign key_o       = w_in_resp ? r_key : '0;
  assign key_err_o   = w_in_resp & r_err;
  assign busy_o      = !w_in_idle;

  // Grant, ROM fetch, response and scrub sequencing with the read-once ledger.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_key    <= '0;
      r_err    <= 1'b0;
      r_used   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_idx;
            r_rr_ptr <= w_ptr_next;
            if (w_ro_violation) begin
              // Repeat request on a read-once slot: skip the ROM, answer with error.
              r_err   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_key   <= rom_rdata_i;
          r_state <= RESP;
        end
        RESP: begin
          if (w_resp_hs) begin
            if (!r_err) begin
              r_used <= r_used | w_grant_onehot;
            end
            r_state <= SCRUB;
          end
        end
        SCRUB: begin
          r_key   <= '0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_dispatch.sv
// Scoreboard bench for key_dispatch with a combinational ROM model.
module tb_key_dispatch;
  import key_dispatch_pkg::*;

  localparam int N = 5;

  localparam logic [191:0] K0 = 192'h55555555_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6;
  localparam logic [191:0] K1 = 192'h2b7e1516_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6;
  localparam logic [191:0] K2 = 192'h000ffff8_ff6ff00f;
  localparam logic [191:0] K3 = 192'h000ff8f8_ff6fe00f;
  localparam logic [191:0] K4 = 192'hffffffff_ffffffff;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [31:0]    rom_addr;
  logic [191:0]   rom_rdata;
  logic [191:0]   key;
  logic [N-1:0]   key_valid;
  logic           key_err;
  logic [N-1:0]   key_ready;
  logic           busy;

  always #5 clk = ~clk;

  key_dispatch dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata),
    .key_o       (key),
    .key_valid_o (key_valid),
    .key_err_o   (key_err),
    .key_ready_i (key_ready),
    .busy_o      (busy)
  );

  function automatic logic [191:0] rom_key(input logic [31:0] a);
    case (a)
      32'd0:   return K0;
      32'd1:   return K1;
      32'd2:   return K2;
      32'd3:   return K3;
      32'd4:   return K4;
      default: return 192'd0;
    endcase
  endfunction

  assign rom_rdata = rom_key(rom_addr);

  typedef struct {
    int           client;
    logic [191:0] key;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input int c, input logic [191:0] k, input logic e);
    exp_t x;
    x.client = c;
    x.key    = k;
    x.err    = e;
    exp_q.push_back(x);
  endtask

  // Pops one expectation per response handshake; also checks key bus is zero when idle.
  task automatic monitor_loop();
    exp_t x;
    forever begin
      neg();
      if (rst_n) begin
        if (key_valid == '0) begin
          chk("key_zero_when_invalid", key, 192'd0);
        end else if ((key_valid & key_ready) != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 192'(key_valid), 192'd0);
          end else begin
            x = exp_q.pop_front();
            chk("resp_client", 192'(key_valid), 192'(5'd1 << x.client));
            chk("resp_key", key, x.key);
            chk("resp_err", 192'(key_err), 192'(x.err));
            $display("resp client=%0d key=%h err=%0d", x.client, key, key_err);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    neg();
    while (busy && n < 40) begin
      neg();
      n++;
    end
    if (busy) chk("idle_timeout", 192'(busy), 192'd0);
  endtask

  // One request from client c while idle, with key_ready already high for c.
  task automatic single_req(input int c, input logic err);
    step();
    req_valid = 5'd1 << c;
    neg();
    chk($sformatf("req_ready_c%0d", c), 192'(req_ready), 192'(5'd1 << c));
    push(c, err ? 192'd0 : rom_key(32'(c)), err);
    $display("req client=%0d err_expected=%0d", c, err);
    step();
    req_valid = '0;
    neg();
    if (err) begin
      chk("err_valid_lat1", 192'(key_valid), 192'(5'd1 << c));
      chk("err_flag", 192'(key_err), 192'd1);
    end else begin
      chk("read_valid_low", 192'(key_valid), 192'd0);
      chk("rom_addr", 192'(rom_addr), 192'(c));
      step();
      neg();
      chk("valid_lat2", 192'(key_valid), 192'(5'd1 << c));
      step();
      neg();
      chk("key_zero_scrub", key, 192'd0);
      chk("busy_scrub", 192'(busy), 192'd1);
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int order[3];
    int got;
    int last;
    int cyc;
    logic [N-1:0] drop;

    rst_n = 1'b0;
    req_valid = '0;
    key_ready = '0;
    fork
      monitor_loop();
    join_none

    // Reset state
    #2;
    chk("rst_busy", 192'(busy), 192'd0);
    chk("rst_req_ready", 192'(req_ready), 192'd0);
    chk("rst_key_valid", 192'(key_valid), 192'd0);
    chk("rst_key", key, 192'd0);
    chk("rst_rom_addr", 192'(rom_addr), 192'd0);
    chk("rst_key_err", 192'(key_err), 192'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single AES request
    key_ready = 5'b00001;
    single_req(CLIENT_AES, 1'b0);

    // Simultaneous 0,2,4 from a fresh pointer
    do_reset();
    key_ready = '1;
    order = '{0, 2, 4};
    got = 0;
    last = 0;
    cyc = 0;
    step();
    req_valid = 5'b10101;
    for (int i = 0; i < 24 && got < 3; i++) begin
      neg();
      drop = '0;
      if (req_ready != '0) begin
        chk("grant_order", 192'(req_ready), 192'(5'd1 << order[got]));
        if (got > 0) chk("grant_spacing", 192'(cyc - last), 192'd4);
        push(order[got], rom_key(32'(order[got])), 1'b0);
        $display("req client=%0d (simultaneous)", order[got]);
        last = cyc;
        drop = req_ready;
        got++;
      end
      step();
      req_valid = req_valid & ~drop;
      cyc++;
    end
    if (got < 3) chk("grant_count", 192'(got), 192'd3);
    req_valid = '0;
    wait_idle();

    // JTAG read-once
    single_req(CLIENT_JTAG, 1'b0);
    single_req(CLIENT_JTAG, 1'b1);
    do_reset();
    single_req(CLIENT_JTAG, 1'b0);

    // Backpressure on client 3 while client 0 waits
    key_ready = '0;
    step();
    req_valid = 5'b01000;
    neg();
    chk("bp_req_ready_c3", 192'(req_ready), 192'(5'b01000));
    push(CLIENT_ACM1, K3, 1'b0);
    $display("req client=3 (backpressure)");
    step();
    req_valid = 5'b00001;
    neg();
    chk("bp_no_accept_read", 192'(req_ready), 192'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      neg();
      chk("bp_valid_hold", 192'(key_valid), 192'(5'b01000));
      chk("bp_key_hold", key, K3);
      chk("bp_no_accept_resp", 192'(req_ready), 192'd0);
      step();
    end
    key_ready = 5'b01000;
    neg();
    chk("bp_no_accept_hs", 192'(req_ready), 192'd0);
    step();
    neg();
    chk("bp_no_accept_scrub", 192'(req_ready), 192'd0);
    chk("bp_scrub_key", key, 192'd0);
    step();
    neg();
    chk("bp_accept_after", 192'(req_ready), 192'(5'b00001));
    push(CLIENT_AES, K0, 1'b0);
    $display("req client=0 (after backpressure)");
    key_ready = '1;
    step();
    req_valid = '0;
    wait_idle();

    // Reset asserted during RESP
    key_ready = '0;
    step();
    req_valid = 5'b00100;
    neg();
    chk("mr_req_ready", 192'(req_ready), 192'(5'b00100));
    push(CLIENT_ACM0, K2, 1'b0);
    $display("req client=2 (reset mid-response)");
    step();
    req_valid = '0;
    step();
    neg();
    chk("mr_in_resp", 192'(key_valid), 192'(5'b00100));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 192'(key_valid), 192'd0);
    chk("mr_async_key", key, 192'd0);
    chk("mr_async_busy", 192'(busy), 192'd0);
    chk("mr_async_err", 192'(key_err), 192'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    neg();
    chk("mr_busy_after", 192'(busy), 192'd0);
    step();
    key_ready = '1;
    req_valid = 5'b10001;
    neg();
    chk("mr_ptr_zero_grant", 192'(req_ready), 192'(5'b00001));
    push(CLIENT_AES, K0, 1'b0);
    $display("req client=0 (after mid-response reset)");
    step();
    req_valid = '0;
    wait_idle();

    // Wrong-client ready while client 2 is in RESP
    key_ready = 5'b00001;
    step();
    req_valid = 5'b00100;
    neg();
    chk("wr_req_ready", 192'(req_ready), 192'(5'b00100));
    push(CLIENT_ACM0, K2, 1'b0);
    $display("req client=2 (wrong-client ready)");
    step();
    req_valid = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("wr_hold_valid", 192'(key_valid), 192'(5'b00100));
      step();
    end
    key_ready = 5'b00100;
    neg();
    step();
    neg();
    chk("wr_done_valid", 192'(key_valid), 192'd0);
    wait_idle();

    chk("queue_empty", 192'(exp_q.size()), 192'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
